cla_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit Carry_lookahead adder between NREQ requesters using a round-robin scheduler.

---
 rtl/cla_pkg.sv | 14 +
 rtl/Carry_lookahead.sv | 42 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cla_share_arbiter.sv | 122 ++++++++++++
 tb/tb_cla_share_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding and id-width helper.
package cla_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Index width for n requesters; never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Carry_lookahead.sv
// Combinational WIDTH-bit carry-lookahead adder: every carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module Carry_lookahead #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             term;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      term = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (g[j] & prop);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import cla_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (int'(ptr) + k) % int'(NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one carry-lookahead adder among NREQ requesters with round-robin
// arbitration, multi-beat carry chaining and a single registered response.
module cla_share_arbiter
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_last,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_last
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   owner;
  logic             carry_q;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  logic             out_free;
  logic [IDW-1:0]   sel;
  logic             accept;
  logic             add_cin;
  logic             sel_last;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [IDW-1:0]   next_ptr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  assign out_free = !rsp_valid || rsp_ready;

  // Grant and adder steering: the owner holds the adder while locked.
  always_comb begin
    req_ready = '0;
    sel       = arb_idx;
    add_cin   = req_cin[arb_idx];
    if (state == ST_LOCKED) begin
      sel     = owner;
      add_cin = carry_q;
      if (!rst && out_free) req_ready[owner] = 1'b1;
    end else if (!rst && out_free && arb_any) begin
      req_ready = arb_grant;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign sel_last = req_last[sel];
  assign next_ptr = IDW'((int'(sel) + 1) % int'(NREQ));

  Carry_lookahead #(.WIDTH(WIDTH)) u_cla (
    .a    (a_arr[sel]),
    .b    (b_arr[sel]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // FSM, chaining state and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      carry_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= sel;
        rsp_last  <= sel_last;
        carry_q   <= add_cout;
        if (sel_last) begin
          state  <= ST_IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state  <= ST_LOCKED;
          owner  <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed scoreboard bench for cla_share_arbiter (WIDTH=16, NREQ=4).
module tb_cla_share_arbiter;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic [1:0]  id;
    logic        last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_last;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;
  logic           rsp_last;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  cla_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [15:0] s, input logic c, input logic l);
    exp_t e;
    e.sum = s; e.cout = c; e.id = id; e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every transferred response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_sum), 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_sum",  32'(rsp_sum),  32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        check("rsp_id",   32'(rsp_id),   32'(e.id));
        check("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
  end

  // Drive one beat on requester i and wait (bounded) for acceptance.
  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic last, input bit push,
                      input logic [15:0] es, input logic ec, output int acc_cyc);
    bit done = 0;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_last[i]     = last;
    req_valid[i]    = 1'b1;
    acc_cyc         = -1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        done    = 1;
        acc_cyc = cyc;
        if (push) push_exp(2'(i), es, ec, last);
      end
    end
    if (!done) check("accept_timeout", 32'(i), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic rr_client(input int i);
    int c;
    send(i, 16'(i*256 + 16), 16'h0001, 1'b0, 1'b1, 0, 16'h0, 1'b0, c);
    send(i, 16'(i*256 + 32), 16'h0001, 1'b0, 1'b1, 0, 16'h0, 1'b0, c);
  endtask

  initial begin
    int c0, c1, ca, cb, t0;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '1; req_a = '0; req_b = '0; req_cin = '0; req_last = '1;

    // Reset state, with every requester asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_sum",   32'(rsp_sum),   32'h0);
    check("reset_rsp_cout",  32'(rsp_cout),  32'h0);
    check("reset_rsp_id",    32'(rsp_id),    32'h0);
    check("reset_rsp_last",  32'(rsp_last),  32'h0);
    @(posedge clk); #1;
    req_valid = '0; rst = 1'b0;

    // Round-robin at full throughput: order 0,1,2,3,0,1,2,3.
    push_exp(0, 16'h0011, 0, 1); push_exp(1, 16'h0111, 0, 1);
    push_exp(2, 16'h0211, 0, 1); push_exp(3, 16'h0311, 0, 1);
    push_exp(0, 16'h0021, 0, 1); push_exp(1, 16'h0121, 0, 1);
    push_exp(2, 16'h0221, 0, 1); push_exp(3, 16'h0321, 0, 1);
    t0 = cyc;
    fork
      rr_client(0);
      rr_client(1);
      rr_client(2);
      rr_client(3);
    join
    check("rr_throughput_cycles", 32'(cyc - t0), 32'd8);

    // Single beat.
    send(0, 16'h1234, 16'h0001, 1'b1, 1'b1, 1, 16'h1236, 1'b0, c0);

    // Two-beat chain: 0x0000FFFF + 1.
    send(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, c0);
    send(2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 16'h0001, 1'b0, c0);

    // Lock: req1 3 beats with a 2-cycle gap, req3 must wait until after the last beat.
    fork
      begin
        send(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1, 16'h0001, 1'b1, c0);
        repeat (2) @(posedge clk);
        #1;
        send(1, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1, 16'h0000, 1'b1, c0);
        send(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 16'h0001, 1'b0, ca);
      end
      begin
        @(posedge clk); #1;
        send(3, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1, 16'h0000, 1'b1, cb);
      end
    join
    check("lock_req3_after_last", 32'(cb - ca), 32'd1);

    // Backpressure: response held 3 cycles, no accepts, then drains with req2 accept.
    send(0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1, 16'h0100, 1'b0, c0);
    rsp_ready = 1'b0;
    fork
      send(2, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 1, 16'h8001, 1'b0, c1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
          check("bp_rsp_sum",   32'(rsp_sum),   32'h0100);
          check("bp_rsp_id",    32'(rsp_id),    32'h0);
          check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join

    // Reset in the middle of a lock held by req1.
    send(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b1, c0);
    @(posedge clk); #1;
    req_a[1*W +: W] = 16'h0005; req_b[1*W +: W] = 16'h0005;
    req_last[1] = 1'b1; req_valid[1] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0; req_valid = '0;
    push_exp(0, 16'h0031, 0, 1);
    push_exp(1, 16'h0002, 0, 1);
    fork
      send(0, 16'h0010, 16'h0020, 1'b1, 1'b1, 0, 16'h0, 1'b0, c0);
      send(1, 16'h0001, 16'h0001, 1'b0, 1'b1, 0, 16'h0, 1'b0, c1);
    join

    // Drain the scoreboard.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
